// File: rtl/jk_reg_bank.sv
// Bank of WIDTH independent JK flip-flops with a bank-wide enable and a parallel load.
// Each channel also has registered rise/fall strobes and a saturating or wrapping change counter.
module jk_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 4,
  parameter bit               SAT     = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIDTH-1:0]       j,
  input  logic [WIDTH-1:0]       k,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_val,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_bar,
  output logic [WIDTH-1:0]       rise,
  output logic [WIDTH-1:0]       fall,
  output logic [WIDTH*CNT_W-1:0] change_cnt
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_chg;

  // At the maximum count, the counter either stays there or wraps to zero.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] v;
    if (c == {CNT_W{1'b1}}) v = SAT ? c : '0;
    else                    v = c + 1'b1;
    return v;
  endfunction

  always_comb begin
    w_q_nxt = r_q;
    if (load) begin
      w_q_nxt = load_val;
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case ({j[i], k[i]})
          2'b00:   w_q_nxt[i] = r_q[i];
          2'b01:   w_q_nxt[i] = 1'b0;
          2'b10:   w_q_nxt[i] = 1'b1;
          default: w_q_nxt[i] = ~r_q[i];
        endcase
      end
    end
  end

  assign w_chg = w_q_nxt ^ r_q;

  // Strobes come from comparing the old and new q, so load-driven changes also pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= RST_VAL;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_q    <= w_q_nxt;
      r_rise <= w_chg & w_q_nxt;
      r_fall <= w_chg & r_q;
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt_clr)       r_cnt[i] <= '0;
        else if (w_chg[i]) r_cnt[i] <= cnt_inc(r_cnt[i]);
      end
    end
  end

  assign q     = r_q;
  assign q_bar = ~r_q;
  assign rise  = r_rise;
  assign fall  = r_fall;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
    assign change_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank. It drives one saturating instance and one wrapping
// instance with the same stimulus and compares both against hand-computed values.
module tb_jk_reg_bank;

  logic        clk = 1'b0;
  logic        rst, en, load, cnt_clr;
  logic [7:0]  j, k, load_val;
  logic [7:0]  q_s, qb_s, rise_s, fall_s, q_w, qb_w, rise_w, fall_w;
  logic [31:0] cnt_s, cnt_w;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(4), .SAT(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .j(j), .k(k), .load(load), .load_val(load_val),
    .cnt_clr(cnt_clr), .q(q_s), .q_bar(qb_s), .rise(rise_s), .fall(fall_s),
    .change_cnt(cnt_s)
  );

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(4), .SAT(1'b0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .j(j), .k(k), .load(load), .load_val(load_val),
    .cnt_clr(cnt_clr), .q(q_w), .q_bar(qb_w), .rise(rise_w), .fall(fall_w),
    .change_cnt(cnt_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; cnt_clr = 1'b0;
    j = 8'h00; k = 8'h00; load_val = 8'h00;
    tick(); tick();
    rst = 1'b0;
    total++; if (q_s !== 8'hA5) begin bad++; $display("FAIL reset_q got=%h exp=a5", q_s); end
    total++; if (qb_s !== 8'h5A) begin bad++; $display("FAIL reset_qbar got=%h exp=5a", qb_s); end
    total++; if (rise_s !== 8'h00 || fall_s !== 8'h00) begin bad++; $display("FAIL reset_strobe got=%h/%h exp=00/00", rise_s, fall_s); end
    total++; if (cnt_s !== 32'h0 || cnt_w !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=0", cnt_s, cnt_w); end
    total++; if (q_w !== 8'hA5) begin bad++; $display("FAIL reset_q_w got=%h exp=a5", q_w); end
  endtask

  task automatic test_jk_setclr();
    en = 1'b1; j = 8'h0F; k = 8'hF0;
    tick();
    total++; if (q_s !== 8'h0F) begin bad++; $display("FAIL jk_q got=%h exp=0f", q_s); end
    total++; if (qb_s !== 8'hF0) begin bad++; $display("FAIL jk_qbar got=%h exp=f0", qb_s); end
    total++; if (rise_s !== 8'h0A) begin bad++; $display("FAIL jk_rise got=%h exp=0a", rise_s); end
    total++; if (fall_s !== 8'hA0) begin bad++; $display("FAIL jk_fall got=%h exp=a0", fall_s); end
    total++; if (cnt_s !== 32'h10101010) begin bad++; $display("FAIL jk_cnt got=%h exp=10101010", cnt_s); end
    en = 1'b0;
    tick();
    total++; if (q_s !== 8'h0F) begin bad++; $display("FAIL hold_q got=%h exp=0f", q_s); end
    total++; if (rise_s !== 8'h00 || fall_s !== 8'h00) begin bad++; $display("FAIL pulse_width got=%h/%h exp=00/00", rise_s, fall_s); end
  endtask

  task automatic test_saturate();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++; if (cnt_s !== 32'h0 || cnt_w !== 32'h0) begin bad++; $display("FAIL clr_idle got=%h/%h exp=0", cnt_s, cnt_w); end
    en = 1'b1; j = 8'hFF; k = 8'hFF;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 15) begin
        total++; if (cnt_s !== 32'hFFFFFFFF || cnt_w !== 32'hFFFFFFFF) begin bad++; $display("FAIL cnt15 got=%h/%h exp=ffffffff", cnt_s, cnt_w); end
      end
      if (n == 16) begin
        total++; if (cnt_s !== 32'hFFFFFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffffffff", cnt_s); end
        total++; if (cnt_w !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=00000000", cnt_w); end
      end
    end
    total++; if (cnt_s !== 32'hFFFFFFFF) begin bad++; $display("FAIL sat20 got=%h exp=ffffffff", cnt_s); end
    total++; if (cnt_w !== 32'h44444444) begin bad++; $display("FAIL wrap20 got=%h exp=44444444", cnt_w); end
    total++; if (q_s !== 8'h0F) begin bad++; $display("FAIL tog_q got=%h exp=0f", q_s); end
    total++; if (rise_s !== 8'h0F || fall_s !== 8'hF0) begin bad++; $display("FAIL tog_strobe got=%h/%h exp=0f/f0", rise_s, fall_s); end
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_val = 8'h3C; en = 1'b1; j = 8'hFF; k = 8'hFF;
    tick();
    load = 1'b0;
    total++; if (q_s !== 8'h3C) begin bad++; $display("FAIL load_q got=%h exp=3c", q_s); end
    total++; if (rise_s !== 8'h30 || fall_s !== 8'h03) begin bad++; $display("FAIL load_strobe got=%h/%h exp=30/03", rise_s, fall_s); end
    total++; if (cnt_w !== 32'h44554455) begin bad++; $display("FAIL load_cnt got=%h exp=44554455", cnt_w); end
    en = 1'b0; j = 8'hFF; k = 8'h00;
    tick();
    total++; if (q_s !== 8'h3C) begin bad++; $display("FAIL en0_q got=%h exp=3c", q_s); end
    total++; if (rise_s !== 8'h00 || fall_s !== 8'h00) begin bad++; $display("FAIL en0_strobe got=%h/%h exp=00/00", rise_s, fall_s); end
  endtask

  task automatic test_cnt_clr();
    en = 1'b1; j = 8'h01; k = 8'h01; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++; if (q_s !== 8'h3D) begin bad++; $display("FAIL clr_q got=%h exp=3d", q_s); end
    total++; if (rise_s !== 8'h01 || fall_s !== 8'h00) begin bad++; $display("FAIL clr_strobe got=%h/%h exp=01/00", rise_s, fall_s); end
    total++; if (cnt_s !== 32'h0 || cnt_w !== 32'h0) begin bad++; $display("FAIL clr_cnt got=%h/%h exp=0", cnt_s, cnt_w); end
    tick();
    total++; if (q_s !== 8'h3C || fall_s !== 8'h01) begin bad++; $display("FAIL resume_q got=%h/%h exp=3c/01", q_s, fall_s); end
    total++; if (cnt_s !== 32'h1 || cnt_w !== 32'h1) begin bad++; $display("FAIL resume_cnt got=%h/%h exp=1", cnt_s, cnt_w); end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; j = 8'hFF; k = 8'hFF;
    tick();
    total++; if (q_s !== 8'hC3) begin bad++; $display("FAIL pre_rst_q got=%h exp=c3", q_s); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (q_s !== 8'hA5 || qb_s !== 8'h5A) begin bad++; $display("FAIL midrst_q got=%h/%h exp=a5/5a", q_s, qb_s); end
    total++; if (rise_s !== 8'h00 || fall_s !== 8'h00) begin bad++; $display("FAIL midrst_strobe got=%h/%h exp=00/00", rise_s, fall_s); end
    total++; if (cnt_s !== 32'h0 || cnt_w !== 32'h0) begin bad++; $display("FAIL midrst_cnt got=%h/%h exp=0", cnt_s, cnt_w); end
    tick();
    total++; if (q_s !== 8'h5A) begin bad++; $display("FAIL postrst_q got=%h exp=5a", q_s); end
    total++; if (rise_s !== 8'h5A || fall_s !== 8'hA5) begin bad++; $display("FAIL postrst_strobe got=%h/%h exp=5a/a5", rise_s, fall_s); end
    total++; if (cnt_s !== 32'h11111111) begin bad++; $display("FAIL postrst_cnt got=%h exp=11111111", cnt_s); end
  endtask

  task automatic test_back_to_back();
    // Per nibble: bit0 toggles, bit1 sets, bit2 clears, bit3 holds.
    j = 8'h33; k = 8'h55;
    tick();
    total++; if (q_s !== 8'h2B || qb_s !== 8'hD4) begin bad++; $display("FAIL mix_q got=%h/%h exp=2b/d4", q_s, qb_s); end
    total++; if (rise_s !== 8'h21 || fall_s !== 8'h50) begin bad++; $display("FAIL mix_strobe got=%h/%h exp=21/50", rise_s, fall_s); end
    total++; if (cnt_s !== 32'h12221112 || cnt_w !== 32'h12221112) begin bad++; $display("FAIL mix_cnt got=%h/%h exp=12221112", cnt_s, cnt_w); end
  endtask

  initial begin
    test_reset();
    test_jk_setclr();
    test_saturate();
    test_load_priority();
    test_cnt_clr();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
